// File: rtl/uart_tx_drain_if.sv
// FIFO read-side bundle between the TX FIFO head and the UART serializer.
interface uart_tx_drain_if;
    logic       i_fifo_empty_n;
    logic [7:0] i_fifo_data;
    logic       o_fifo_rd;

    modport master (
        output i_fifo_empty_n,
        output i_fifo_data,
        input  o_fifo_rd
    );

    modport slave (
        input  i_fifo_empty_n,
        input  i_fifo_data,
        output o_fifo_rd
    );
endinterface

// File: rtl/uart_tx_drain.sv
// 8N1 UART transmitter draining a TX FIFO, runtime baud divisor and line break.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 framing).
module uart_tx_drain #(
    parameter int            DW          = 24,
    parameter logic [DW-1:0] INITIAL_DIV = DW'(868)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DW-1:0]     i_div,
    input  logic              i_div_valid,
    uart_tx_drain_if.slave    fifo,
    input  logic              i_break,
    output logic              o_uart_tx,
    output logic              o_busy
);
    localparam logic [DW-1:0] ONE = DW'(1);
    localparam logic [DW-1:0] TWO = DW'(2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t        state;
    logic [DW-1:0] shadow;
    logic [DW-1:0] div_act;
    logic [DW-1:0] cnt;
    logic [DW-1:0] d_next;
    logic [7:0]    sh;
    logic [2:0]    idx;
    logic          tx;
    logic          pop;
`ifdef UART_TX_PARITY_EN
    logic          par;
`endif

    assign d_next = (shadow < TWO) ? TWO : shadow;

    // Pop only from IDLE; break wins over pending data
    assign pop = (state == S_IDLE) && !i_break
              && fifo.i_fifo_empty_n && !i_rst;

    assign fifo.o_fifo_rd = pop;
    assign o_uart_tx      = tx;
    assign o_busy         = (state != S_IDLE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= S_IDLE;
            shadow  <= INITIAL_DIV;
            div_act <= INITIAL_DIV;
            cnt     <= '0;
            sh      <= '0;
            idx     <= '0;
            tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            if (i_div_valid)
                shadow <= i_div;
            unique case (state)
                S_IDLE: begin
                    if (i_break) begin
                        state <= S_BREAK;
                        tx    <= 1'b0;
                    end else if (fifo.i_fifo_empty_n) begin
                        sh      <= fifo.i_fifo_data;
                        div_act <= d_next;
                        cnt     <= d_next - ONE;
                        state   <= S_START;
                        tx      <= 1'b0;
`ifdef UART_TX_PARITY_EN
                        par     <= ^fifo.i_fifo_data;
`endif
                    end
                end
                S_START: begin
                    if (cnt == '0) begin
                        state <= S_DATA;
                        cnt   <= div_act - ONE;
                        idx   <= '0;
                        tx    <= sh[0];
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
                S_DATA: begin
                    if (cnt == '0) begin
                        cnt <= div_act - ONE;
                        if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= S_PARITY;
                            tx    <= par;
`else
                            state <= S_STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            idx <= idx + 3'd1;
                            sh  <= {1'b0, sh[7:1]};
                            tx  <= sh[1];
                        end
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (cnt == '0) begin
                        state <= S_STOP;
                        cnt   <= div_act - ONE;
                        tx    <= 1'b1;
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
`endif
                S_STOP: begin
                    if (cnt == '0)
                        state <= S_IDLE;
                    else
                        cnt <= cnt - ONE;
                end
                S_BREAK: begin
                    // Recovery: one full stop bit high before accepting data
                    if (!i_break) begin
                        state <= S_STOP;
                        cnt   <= div_act - ONE;
                        tx    <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_drain.sv
// Bench for uart_tx_drain: FIFO model, frame-level line reference, directed and random frames.
module tb_uart_tx_drain;
    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] div;
    logic          dv;
    logic          brk;
    logic          tx;
    logic          busy;

    uart_tx_drain_if ifc ();

    uart_tx_drain #(
        .DW          (DW),
        .INITIAL_DIV (24'd6)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_div       (div),
        .i_div_valid (dv),
        .fifo        (ifc.slave),
        .i_break     (brk),
        .o_uart_tx   (tx),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:63];
    int wp = 0;
    int rp = 0;
    int underflow = 0;
    int exp_pops = 0;
    int n_assert = 0;
    int n_fail = 0;

    assign ifc.i_fifo_empty_n = (wp != rp);
    assign ifc.i_fifo_data    = mem[rp[5:0]];

    always @(posedge clk) begin
        if (ifc.o_fifo_rd) begin
            if (wp == rp) underflow <= underflow + 1;
            else          rp <= rp + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wp[5:0]] = b;
        wp = wp + 1;
    endtask

    task automatic set_div(input logic [DW-1:0] d);
        div = d;
        dv  = 1'b1;
        @(negedge clk);
        dv  = 1'b0;
    endtask

    task automatic idle_chk(input string tag);
        @(negedge clk);
        chk({tag, "_tx"}, {31'd0, tx}, 1);
        chk({tag, "_busy"}, {31'd0, busy}, 0);
        chk({tag, "_rd"}, {31'd0, ifc.o_fifo_rd}, 0);
    endtask

    // Pop may already be asserted in the current cycle
    task automatic wait_pop(input string tag);
        int k = 0;
        #1;
        while (!ifc.o_fifo_rd && k < 300) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk({tag, "_rd"}, {31'd0, ifc.o_fifo_rd}, 1);
        chk({tag, "_busy"}, {31'd0, busy}, 0);
        exp_pops++;
    endtask

    task automatic expect_pop(input string tag);
        @(negedge clk);
        chk({tag, "_rd"}, {31'd0, ifc.o_fifo_rd}, 1);
        chk({tag, "_busy"}, {31'd0, busy}, 0);
        chk({tag, "_tx"}, {31'd0, tx}, 1);
        exp_pops++;
    endtask

    // Expected line: start, 8 data LSB first, [parity], stop; d clocks each
    task automatic check_frame(input logic [7:0] b, input int d,
                               input int ev_at, input int ev_kind,
                               input logic [DW-1:0] ev_div);
        logic lv[$];
        repeat (d) lv.push_back(1'b0);
        for (int i = 0; i < 8; i++)
            repeat (d) lv.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
        repeat (d) lv.push_back(^b);
`endif
        repeat (d) lv.push_back(1'b1);
        for (int i = 0; i < lv.size(); i++) begin
            @(negedge clk);
            chk($sformatf("frm%02h_tx%0d", b, i), {31'd0, tx}, {31'd0, lv[i]});
            chk($sformatf("frm%02h_busy%0d", b, i), {31'd0, busy}, 1);
            chk($sformatf("frm%02h_rd%0d", b, i), {31'd0, ifc.o_fifo_rd}, 0);
            dv = 1'b0;
            if (i == ev_at) begin
                if (ev_kind == 1) begin
                    div = ev_div;
                    dv  = 1'b1;
                end else if (ev_kind == 2) begin
                    brk = 1'b1;
                end
            end
        end
        dv = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rb [0:9];
        int         d;
        int         nd;

        rst = 1'b1;
        div = '0;
        dv  = 1'b0;
        brk = 1'b0;
        repeat (3) idle_chk("reset");

        rst = 1'b0;
        set_div(24'd4);
        idle_chk("idle_empty");

        push(8'hA5);
        wait_pop("pop_a5");
        check_frame(8'hA5, 4, -1, 0, '0);
        repeat (3) idle_chk("after_a5");

        set_div(24'd3);
        push(8'h00);
        push(8'hFF);
        wait_pop("pop_00");
        check_frame(8'h00, 3, -1, 0, '0);
        expect_pop("pop_ff");
        check_frame(8'hFF, 3, -1, 0, '0);
        repeat (2) idle_chk("after_ff");

        // Divisor 1 clamps to 2; change mid-frame applies to next byte only
        set_div(24'd1);
        push(8'h55);
        push(8'h5A);
        wait_pop("pop_55");
        check_frame(8'h55, 2, 5, 1, 24'd5);
        expect_pop("pop_5a");
        check_frame(8'h5A, 5, -1, 0, '0);
        idle_chk("after_5a");

        set_div(24'd4);
        push(8'h0F);
        push(8'h3C);
        wait_pop("pop_0f");
        check_frame(8'h0F, 4, 10, 2, '0);
        idle_chk("brk_idle");
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("brk_low_tx", {31'd0, tx}, 0);
            chk("brk_low_busy", {31'd0, busy}, 1);
            chk("brk_low_rd", {31'd0, ifc.o_fifo_rd}, 0);
            if (i == 49) brk = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("brk_stop_tx", {31'd0, tx}, 1);
            chk("brk_stop_busy", {31'd0, busy}, 1);
            chk("brk_stop_rd", {31'd0, ifc.o_fifo_rd}, 0);
        end
        expect_pop("pop_3c");
        check_frame(8'h3C, 4, -1, 0, '0);
        idle_chk("after_3c");

        set_div(24'd2);
        push(8'h07);
        push(8'h03);
        wait_pop("pop_07");
        check_frame(8'h07, 2, -1, 0, '0);
        expect_pop("pop_03");
        check_frame(8'h03, 2, -1, 0, '0);
        idle_chk("after_03");

        // Reset 17 clocks into a D=4 frame; divisor returns to INITIAL_DIV
        set_div(24'd4);
        push(8'h96);
        push(8'h69);
        wait_pop("pop_96");
        repeat (16) begin
            @(negedge clk);
            chk("mid_busy", {31'd0, busy}, 1);
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_tx", {31'd0, tx}, 1);
            chk("rst_busy", {31'd0, busy}, 0);
            chk("rst_rd", {31'd0, ifc.o_fifo_rd}, 0);
        end
        chk("rst_pops", rp, exp_pops);
        rst = 1'b0;
        wait_pop("pop_69");
        check_frame(8'h69, 6, -1, 0, '0);
        idle_chk("after_69");

        d = 2 + int'($urandom_range(0, 4));
        set_div(DW'(d));
        for (int k = 0; k < 10; k++) begin
            rb[k] = 8'($urandom);
            push(rb[k]);
        end
        for (int k = 0; k < 10; k++) begin
            nd = int'($urandom_range(0, 6));
            if (k == 0) wait_pop("rnd_pop");
            else        expect_pop("rnd_pop");
            check_frame(rb[k], d, int'($urandom_range(0, 15)), 1, DW'(nd));
            d = (nd < 2) ? 2 : nd;
        end
        repeat (3) idle_chk("final_idle");

        chk("underflow", underflow, 0);
        chk("pop_count", rp, exp_pops);
        chk("fifo_drained", rp, wp);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_drain.md
Name: uart_tx_drain

Overview:
- UART serializer that is the read end of the transmit FIFO.
- Pops bytes from a FIFO using its o_empty_n / i_rd / o_data semantics. The FIFO presents valid data whenever empty_n is high; a one-cycle rd pops it, and the next word is valid the following clock.
- Drives an 8N1 serial line with a runtime clocks-per-baud divisor and a line-break request.
- Sits between the TX FIFO and the pad.

Parameters:
- INITIAL_DIV, 24'd868, divisor used when i_div_valid is never asserted (115200 baud at 100 MHz).
- DW, 24, width of the divisor.

Ports:
- i_clk  input  1  clock
- i_rst  input  1  synchronous active-high reset
- i_div  input  DW  clocks per baud bit; sampled only when i_div_valid is high
- i_div_valid  input  1  load i_div into the shadow divisor register
- i_fifo_empty_n  input  1  FIFO holds at least one byte; i_fifo_data is valid
- i_fifo_data  input  8  byte at the FIFO head
- o_fifo_rd  output  1  one-cycle pop strobe to the FIFO
- i_break  input  1  request a line break (continuous low)
- o_uart_tx  output  1  serial line, idle high
- o_busy  output  1  frame, break, or break-recovery in progress

Behaviour:
- Clock i_clk; reset i_rst, synchronous, active-high.
- Reset values:
  - o_uart_tx=1, o_fifo_rd=0, o_busy=0.
  - State IDLE; shadow divisor=INITIAL_DIV; baud counter=0.
- Divisor:
  - Shadow register updated on any cycle with i_div_valid.
  - Copied into the active divisor D only at the pop cycle, so a mid-frame change never distorts the current frame.
  - D < 2 is clamped to 2.
- States: IDLE, START, DATA, [PARITY], STOP, BREAK.
- IDLE:
  - If i_break=1: go to BREAK (priority over data).
  - Else if i_fifo_empty_n=1: assert o_fifo_rd for exactly this cycle, latch i_fifo_data into the shift register, latch D, go to START.
  - o_fifo_rd is registered-equivalent: it is never high outside IDLE and never high two cycles in a row.
- Bit timing:
  - Each of START/DATA/PARITY/STOP lasts exactly D clocks.
  - Baud counter loads D-1 on state entry; the state advances when the counter reaches 0.
- Line levels:
  - START: o_uart_tx=0.
  - DATA: 8 bits, LSB first; a 3-bit index counts 0..7 and exits after bit 7.
  - STOP: o_uart_tx=1.
- Line update: o_uart_tx changes on the first clock of each bit, driven from a register.
- Frame period:
  - Back-to-back bytes: 10·D+1 clocks start-edge to start-edge (one IDLE cycle after STOP).
  - First start bit goes low the cycle after o_fifo_rd.
- BREAK:
  - o_uart_tx=0 while i_break=1.
  - On release, enter STOP (D clocks high) before returning to IDLE.
  - i_break asserted mid-frame is ignored until the frame completes.
- o_busy=1 in every state except IDLE.
- FIFO empty at IDLE: no pop, line stays high, o_busy=0.
- Reset mid-frame: next cycle o_uart_tx=1, state IDLE; the byte in flight is lost; no extra pop.
- Never pops when i_fifo_empty_n=0 (no FIFO underflow generated).

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state inserted between DATA and STOP, D clocks long.
  - Drives the even-parity bit (XOR of the 8 data bits); frame becomes 11·D, period 11·D+1.
- Undefined: no PARITY state, no parity logic; 8N1 only.

Test Plan:
- Reset, D=4, FIFO holding 0xA5 → one o_fifo_rd pulse; line low 4 clks, then bits 1,0,1,0,0,1,0,1 (4 clks each), high 4 clks; o_busy high 40 clks.
- FIFO holding 0x00, 0xFF, D=3 → two pops 31 clks apart; second start edge 31 clks after first; no pop while empty.
- i_div=1 with i_div_valid, then byte 0x55 → each bit lasts 2 clks (clamp).
- i_break raised mid-frame of 0x0F, held 50 clks → frame completes intact, then line low 50 clks, then high D clks, then next byte popped.
- i_rst asserted at clock 17 of a D=4 frame → next cycle tx=1, busy=0, rd=0; the following pop occurs only after reset is released.
- With UART_TX_PARITY_EN, byte 0x07, D=2 → parity bit 1 after bit 7; frame 22 clks; 0x03 → parity 0.
